booth16_pp_accumulator: RTL and testbench

//  Consumer end of the radix-16 Booth multiplier datapath. Issues the load strobe to the

---
 rtl/booth16_pp_accumulator.sv | 159 +++++++++++++++
 tb/tb_booth16_pp_accumulator.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/booth16_pp_accumulator.sv
// booth16_pp_accumulator
//   Consumer end of the radix-16 Booth multiplier. Strobes the external shift
//   register to load Q, then consumes one {digit, last_bit} window per cycle.
//   Each window is recoded to a signed digit in -8..+8, and digit*M*16^i is
//   accumulated. The signed 2*WIDTH product is returned over valid/ready.
//
// Optional feature macro: BOOTH16_ABORT_EN (adds i_abort).
//
// Ports
//   clk, rst_n       clock (rising edge), async active-low reset
//   i_start          request a multiply, honoured only in IDLE
//   i_multiplicand   signed M, captured on the start-accept edge
//   i_digit          shift-register dout (current Q nibble)
//   i_last_bit       bit below the current nibble (0 for the first window)
//   o_sr_load        shift-register load strobe (combinational)
//   o_busy           high in RUN and DONE
//   o_prod_valid     product valid
//   i_prod_ready     downstream accepts the product
//   o_product        signed M*Q
//   i_abort          (BOOTH16_ABORT_EN only) drop the current job in RUN/DONE
module booth16_pp_accumulator #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_multiplicand,
  input  logic [3:0]         i_digit,
  input  logic               i_last_bit,
`ifdef BOOTH16_ABORT_EN
  input  logic               i_abort,
`endif
  output logic               o_sr_load,
  output logic               o_busy,
  output logic               o_prod_valid,
  input  logic               i_prod_ready,
  output logic [2*WIDTH-1:0] o_product
);
  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int MW = WIDTH + 4;  // holds +-8M without overflow
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                     r_state, w_state_nxt;
  logic signed [MW-1:0]       r_m1, r_m3, r_m5, r_m7;
  logic signed [2*WIDTH-1:0]  r_acc, r_prod;
  logic [CW-1:0]              r_cnt;
  logic                       r_vld;

  logic                       w_abort;
  logic                       w_accept, w_finish, w_handoff;
  logic signed [MW-1:0]       w_m1, w_sel, w_pp;
  logic signed [4:0]          w_d;
  logic [4:0]                 w_mag;
  logic                       w_neg;
  logic signed [2*WIDTH-1:0]  w_pp_ext, w_acc_nxt;

`ifdef BOOTH16_ABORT_EN
  assign w_abort = i_abort & (r_state != S_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_m1 = {{4{i_multiplicand[WIDTH-1]}}, i_multiplicand};

  // digit value: nibble read as signed, plus the borrowed bit from below
  assign w_d   = $signed({i_digit[3], i_digit}) + $signed({4'b0000, i_last_bit});
  assign w_neg = w_d[4];
  assign w_mag = w_neg ? 5'(-w_d) : 5'(w_d);

  // |d|*M from the odd multiples and shifts
  always_comb begin
    w_sel = '0;
    case (w_mag)
      5'd1:    w_sel = r_m1;
      5'd2:    w_sel = r_m1 <<< 1;
      5'd3:    w_sel = r_m3;
      5'd4:    w_sel = r_m1 <<< 2;
      5'd5:    w_sel = r_m5;
      5'd6:    w_sel = r_m3 <<< 1;
      5'd7:    w_sel = r_m7;
      5'd8:    w_sel = r_m1 <<< 3;
      default: w_sel = '0;
    endcase
  end

  assign w_pp      = w_neg ? -w_sel : w_sel;
  assign w_pp_ext  = {{(2*WIDTH-MW){w_pp[MW-1]}}, w_pp};
  assign w_acc_nxt = r_acc + (w_pp_ext << {r_cnt, 2'b00});

  assign w_accept  = (r_state == S_IDLE) & i_start;
  assign w_finish  = (r_state == S_RUN) & (r_cnt == LAST) & ~w_abort;
  assign w_handoff = (r_state == S_DONE) & r_vld & i_prod_ready & ~w_abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_sr_load   = 1'b0;
    o_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_sr_load = i_start;
        if (i_start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        o_busy = 1'b1;
        if (w_abort)                  w_state_nxt = S_IDLE;
        else if (r_cnt == LAST)       w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_busy = 1'b1;
        if (w_abort)                  w_state_nxt = S_IDLE;
        else if (r_vld & i_prod_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m1   <= '0;
      r_m3   <= '0;
      r_m5   <= '0;
      r_m7   <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_prod <= '0;
      r_vld  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_m1  <= w_m1;
        r_m3  <= w_m1 + (w_m1 <<< 1);
        r_m5  <= w_m1 + (w_m1 <<< 2);
        r_m7  <= (w_m1 <<< 3) - w_m1;
        r_acc <= '0;
        r_cnt <= '0;
      end else if (r_state == S_RUN && !w_abort) begin
        r_acc <= w_acc_nxt;
        if (r_cnt != LAST) r_cnt <= r_cnt + 1'b1;
      end
      if (w_finish) begin
        r_prod <= w_acc_nxt;
        r_vld  <= 1'b1;
      end else if (w_handoff || w_abort) begin
        r_vld  <= 1'b0;
      end
    end
  end

  assign o_prod_valid = r_vld;
  assign o_product    = r_prod;

endmodule

// File: tb/tb_booth16_pp_accumulator.sv
// Bench for booth16_pp_accumulator (WIDTH=16). Models the multiplier shift
// register feeding the DUT and checks results against plain integer products.
module tb_booth16_pp_accumulator;
  localparam int W = 16;
  localparam int N = W / 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  mcand = '0;
  logic [W-1:0]  q_in = '0;
  logic          abort = 1'b0;
  logic          prod_ready = 1'b1;
  logic          sr_load, busy, prod_valid;
  logic [2*W-1:0] product;

  logic [W-1:0]  sr;
  logic          lb;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  booth16_pp_accumulator #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start        (start),
    .i_multiplicand (mcand),
    .i_digit        (sr[3:0]),
    .i_last_bit     (lb),
`ifdef BOOTH16_ABORT_EN
    .i_abort        (abort),
`endif
    .o_sr_load      (sr_load),
    .o_busy         (busy),
    .o_prod_valid   (prod_valid),
    .i_prod_ready   (prod_ready),
    .o_product      (product)
  );

  // Multiplier shift register: loads Q on sr_load, then shifts a nibble per cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
      lb <= 1'b0;
    end else if (sr_load) begin
      sr <= q_in;
      lb <= 1'b0;
    end else begin
      lb <= sr[3];
      sr <= {4'b0000, sr[W-1:4]};
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [W-1:0] m, input logic [W-1:0] q);
    int mi, qi;
    mi = $signed(m);
    qi = $signed(q);
    return 32'(mi * qi);
  endfunction

  // One full multiply. hold: DONE cycles with prod_ready low before acceptance.
  // start_cyc: RUN cycle index (1-based after accept) in which to pulse start.
  // hs_start: raise start in the cycle DONE hands off.
  task automatic run_mul(input logic [W-1:0] m, input logic [W-1:0] q,
                         input int hold, input int start_cyc, input bit hs_start);
    int cyc;
    logic [31:0] e;
    e = ref_mul(m, q);
    @(negedge clk);
    mcand = m; q_in = q; prod_ready = (hold == 0); start = 1'b1;
    #1 chk("sr_load_on_start", 64'(sr_load), 64'd1);
    chk("busy_idle", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b0; mcand = W'($urandom); q_in = W'($urandom);
    chk("busy_run", 64'(busy), 64'd1);
    chk("sr_load_pulse", 64'(sr_load), 64'd0);
    cyc = 1;
    while (!prod_valid && cyc < 20) begin
      start = (cyc == start_cyc);
      if (start) #1 chk("sr_load_ignored_run", 64'(sr_load), 64'd0);
      @(negedge clk);
      cyc++;
      start = 1'b0;
    end
    chk("latency", 64'(cyc), 64'(N + 1));
    chk("product", 64'(product), 64'(e));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        chk("hold_valid", 64'(prod_valid), 64'd1);
        chk("hold_product", 64'(product), 64'(e));
        chk("hold_busy", 64'(busy), 64'd1);
        @(negedge clk);
      end
      prod_ready = 1'b1;
      chk("valid_at_accept", 64'(prod_valid), 64'd1);
    end
    if (hs_start) begin
      start = 1'b1;
      #1 chk("sr_load_ignored_done", 64'(sr_load), 64'd0);
    end
    @(negedge clk);
    start = 1'b0;
    chk("valid_cleared", 64'(prod_valid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("product_kept", 64'(product), 64'(e));
  endtask

  initial begin
    logic [W-1:0] m, q;
    logic [31:0] prev;
    #1;
    chk("rst_sr_load", 64'(sr_load), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(prod_valid), 64'd0);
    chk("rst_product", 64'(product), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_mul(16'd3, 16'd5, 0, 0, 1'b0);                 // T1
    chk("t1_value", 64'(product), 64'h0000000F);
    run_mul(16'h8000, 16'h8000, 0, 0, 1'b0);           // T2
    chk("t2a_value", 64'(product), 64'h40000000);
    run_mul(16'h7FFF, 16'hFFFF, 0, 0, 1'b0);
    chk("t2b_value", 64'(product), 64'hFFFF8001);
    run_mul(16'd0, 16'hA5A5, 0, 0, 1'b0);              // T3
    run_mul(16'h1234, 16'd0, 0, 0, 1'b0);
    run_mul(16'hFFF9, 16'd9, 3, 0, 1'b0);              // T4
    run_mul(16'h0101, 16'h8888, 0, 2, 1'b1);           // T5 start in RUN / handoff

    // T5: reset mid-RUN
    @(negedge clk);
    mcand = 16'h5555; q_in = 16'h7777; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_valid", 64'(prod_valid), 64'd0);
    chk("midrst_product", 64'(product), 64'd0);
    chk("midrst_sr_load", 64'(sr_load), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("midrst_no_valid", 64'(prod_valid), 64'd0);
    end
    run_mul(16'd2, 16'hFFFD, 0, 0, 1'b0);
    chk("t5_value", 64'(product), 64'hFFFFFFFA);

`ifdef BOOTH16_ABORT_EN
    // T6: abort in the third RUN cycle
    prev = product;
    @(negedge clk);
    mcand = 16'd77; q_in = 16'd99; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    repeat (6) begin
      chk("abort_no_valid", 64'(prod_valid), 64'd0);
      chk("abort_product", 64'(product), 64'(prev));
      @(negedge clk);
    end
    run_mul(16'd100, 16'd100, 0, 0, 1'b0);
    chk("t6_value", 64'(product), 64'h00002710);
`endif

    for (int k = 0; k < 40; k++) begin
      m = W'($urandom);
      q = W'($urandom);
      if (k % 8 == 0) m = 16'h8000;
      if (k % 8 == 1) q = 16'h8000;
      if (k % 8 == 2) q = 16'hFFFF;
      run_mul(m, q, int'($urandom_range(0, 2)), 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
